// File: rtl/p20_obstacle_sched_if.sv
// Spawn request channel from the obstacle scheduler to the renderer.
// Master raises spawn_valid with a stable spawn_kind until spawn_ready.
interface p20_obstacle_sched_if;
   logic       spawn_valid;
   logic       spawn_ready;
   logic [1:0] spawn_kind;

   modport master (output spawn_valid, output spawn_kind, input spawn_ready);
   modport slave  (input spawn_valid, input spawn_kind, output spawn_ready);
endinterface

// File: rtl/p20_obstacle_sched.sv
// Obstacle spawn scheduler: stirs the cactus LFSR and offers spawns.
// Define P20_BIRD_EN to allow bird obstacles at high speed levels.
module p20_obstacle_sched #(
   parameter int MIN_GAP    = 24,
   parameter int FLOOR_GAP  = 12,
   parameter int STIR_STEPS = 3,
   parameter int GAP_W      = 8
`ifdef P20_BIRD_EN
   ,
   parameter int BIRD_LEVEL = 4
`endif
) (
   input  logic                 clk,
   input  logic                 sys_rst,
   input  logic                 game_run,
   input  logic                 frame_tick,
   input  logic [3:0]           speed_level,
   input  logic [4:0]           rng_value,
   output logic                 rng_step,
   output logic                 busy,
   p20_obstacle_sched_if.master spawn
);

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      DRAW,
      SAMPLE,
      OFFER
   } state_t;

   state_t             state, state_nxt;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
   logic [GAP_W-1:0]   gap_nxt, gap_nxt_d;
   logic [GAP_W-1:0]   gap_sel;
   logic [2:0]         stir_cnt, stir_cnt_d;
   logic [1:0]         kind, kind_d, kind_draw;
   logic signed [GAP_W:0] gap_raw;

   // One extra bit keeps MIN_GAP + rng - 2*speed from wrapping when negative.
   always_comb begin
      gap_raw = $signed({1'b0, GAP_W'(MIN_GAP)})
              + $signed({{(GAP_W-4){1'b0}}, rng_value})
              - $signed({{(GAP_W-4){1'b0}}, speed_level, 1'b0});
      if (gap_raw < $signed({1'b0, GAP_W'(FLOOR_GAP)}))
         gap_sel = GAP_W'(FLOOR_GAP);
      else
         gap_sel = gap_raw[GAP_W-1:0];
   end

   always_comb begin
      kind_draw = 2'b00;
      if (rng_value[1:0] == 2'b10) begin
         kind_draw = 2'b10;
      end else if (rng_value[1:0] == 2'b11) begin
`ifdef P20_BIRD_EN
         kind_draw = (speed_level >= 4'(BIRD_LEVEL)) ? 2'b11 : 2'b10;
`else
         kind_draw = 2'b10;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         gap_cnt  <= '0;
         gap_nxt  <= '0;
         stir_cnt <= '0;
         kind     <= 2'b00;
      end else begin
         state    <= state_nxt;
         gap_cnt  <= gap_cnt_d;
         gap_nxt  <= gap_nxt_d;
         stir_cnt <= stir_cnt_d;
         kind     <= kind_d;
      end
   end

   always_comb begin
      state_nxt  = state;
      gap_cnt_d  = gap_cnt;
      gap_nxt_d  = gap_nxt;
      stir_cnt_d = stir_cnt;
      kind_d     = kind;
      if (state != IDLE && !game_run) begin
         state_nxt  = IDLE;
         stir_cnt_d = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (game_run) begin
                  gap_cnt_d = GAP_W'(MIN_GAP);
                  state_nxt = GAP;
               end
            end
            GAP: begin
               if (frame_tick) begin
                  gap_cnt_d = gap_cnt - GAP_W'(1);
                  if (gap_cnt == GAP_W'(1)) begin
                     state_nxt  = DRAW;
                     stir_cnt_d = '0;
                  end
               end
            end
            DRAW: begin
               stir_cnt_d = stir_cnt + 3'd1;
               if (stir_cnt == 3'(STIR_STEPS - 1))
                  state_nxt = SAMPLE;
            end
            SAMPLE: begin
               kind_d    = kind_draw;
               gap_nxt_d = gap_sel;
               state_nxt = OFFER;
            end
            OFFER: begin
               if (spawn.spawn_ready) begin
                  gap_cnt_d = gap_nxt;
                  state_nxt = GAP;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign rng_step          = (state == DRAW);
   assign busy              = (state != IDLE);
   assign spawn.spawn_valid = (state == OFFER);
   assign spawn.spawn_kind  = kind;

endmodule

// File: tb/tb_p20_obstacle_sched.sv
// Randomized bench for p20_obstacle_sched with a rotating 5-bit rng stand-in.
// Spawn kind, gap and timing are predicted from the draw rules directly.
module tb_p20_obstacle_sched;
   localparam int MIN_GAP   = 24;
   localparam int FLOOR_GAP = 12;
   localparam int STIR      = 3;

   logic       clk = 1'b0;
   logic       sys_rst;
   logic       game_run;
   logic       frame_tick;
   logic [3:0] speed_level;
   logic [4:0] rng;
   logic [4:0] rng_value;
   logic       rng_step;
   logic       busy;
   logic       stub_en;

   int n_chk  = 0;
   int n_fail = 0;
   int steps;
   int exp_gap;

   p20_obstacle_sched_if spawn ();

   p20_obstacle_sched dut (
      .clk         (clk),
      .sys_rst     (sys_rst),
      .game_run    (game_run),
      .frame_tick  (frame_tick),
      .speed_level (speed_level),
      .rng_value   (rng_value),
      .rng_step    (rng_step),
      .busy        (busy),
      .spawn       (spawn)
   );

   always #5 clk = ~clk;

   // Stand-in for p20_rng: advances one position per entropy pulse.
   always_ff @(posedge clk) begin
      if (sys_rst)
         rng <= 5'd1;
      else if (rng_step)
         rng <= {rng[3:0], rng[4]};
   end

   assign rng_value = stub_en ? 5'b00011 : rng;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int rng_after(input int n);
      return 1 << (n % 5);
   endfunction

   function automatic int model_kind(input int v, input int s);
      int b;
      b = v % 4;
      if (b < 2) return 0;
      if (b == 2) return 2;
`ifdef P20_BIRD_EN
      return (s >= 4) ? 3 : 2;
`else
      return (s < 0) ? 3 : 2;
`endif
   endfunction

   function automatic int model_gap(input int v, input int s);
      int g;
      g = MIN_GAP + v - 2 * s;
      return (g < FLOOR_GAP) ? FLOOR_GAP : g;
   endfunction

   // mode 0 normal, 1 abort in DRAW, 2 abort in OFFER, 3 reset in GAP
   task automatic run_obs(input int mode, input int delay, input int spd);
      int ticks = 0;
      int guard = 0;
      int bad   = 0;
      int hold  = 0;
      int ab;
      int v;
      logic [4:0] spat;
      logic [4:0] vpat;
      logic [1:0] kh;
      speed_level = 4'(spd);
      while (ticks < exp_gap && guard < 3000) begin
         cyc();
         guard++;
         if (rng_step || spawn.spawn_valid || !busy) bad++;
         frame_tick = ($urandom_range(0, 2) == 0);
         if (mode == 3 && ticks == exp_gap / 2) begin
            frame_tick = 1'b0;
            sys_rst = 1'b1;
            cyc();
            sys_rst = 1'b0;
            chk("rst_busy", busy, 0);
            chk("rst_valid", spawn.spawn_valid, 0);
            chk("rst_step", rng_step, 0);
            chk("rst_kind", spawn.spawn_kind, 0);
            chk("rst_gap_outputs", bad, 0);
            steps = 0;
            exp_gap = MIN_GAP;
            return;
         end
         if (frame_tick) ticks++;
      end
      chk("gap_outputs", bad, 0);
      chk("gap_timeout", int'(guard < 3000), 1);
      if (mode == 1) begin
         ab = $urandom_range(1, STIR);
         for (int c = 1; c <= ab; c++) begin
            cyc();
            if (!rng_step) bad++;
            frame_tick = ($urandom_range(0, 2) == 0);
         end
         game_run = 1'b0;
         cyc();
         chk("abort_draw_step_seen", bad, 0);
         chk("abort_draw_step", rng_step, 0);
         chk("abort_draw_busy", busy, 0);
         steps += ab;
         chk("abort_draw_rng", rng, rng_after(steps));
         game_run = 1'b1;
         frame_tick = 1'b0;
         exp_gap = MIN_GAP;
         return;
      end
      spat = '0;
      vpat = '0;
      for (int c = 1; c <= STIR + 2; c++) begin
         cyc();
         spat = {spat[3:0], rng_step};
         vpat = {vpat[3:0], spawn.spawn_valid};
         frame_tick = ($urandom_range(0, 2) == 0);
      end
      chk("stir_pattern", spat, ((1 << STIR) - 1) << 2);
      chk("valid_latency", vpat, 1);
      v = stub_en ? 3 : rng_after(steps + STIR);
      steps += STIR;
      chk("rng_steps", rng, rng_after(steps));
      chk("kind", spawn.spawn_kind, model_kind(v, spd));
      if (mode == 2) begin
         spawn.spawn_ready = 1'b0;
         game_run = 1'b0;
         cyc();
         chk("abort_offer_valid", spawn.spawn_valid, 0);
         chk("abort_offer_busy", busy, 0);
         spawn.spawn_ready = 1'b1;
         game_run = 1'b1;
         frame_tick = 1'b0;
         exp_gap = MIN_GAP;
         return;
      end
      kh = spawn.spawn_kind;
      spawn.spawn_ready = (delay == 0);
      for (int d = 1; d <= delay; d++) begin
         cyc();
         if (!spawn.spawn_valid || spawn.spawn_kind != kh) hold++;
         frame_tick = ($urandom_range(0, 2) == 0);
         spawn.spawn_ready = (d == delay);
      end
      if (delay > 0) chk("offer_hold", hold, 0);
      exp_gap = model_gap(v, spd);
   endtask

   initial begin
      sys_rst = 1'b1;
      game_run = 1'b0;
      frame_tick = 1'b0;
      speed_level = 4'd0;
      stub_en = 1'b0;
      spawn.spawn_ready = 1'b1;
      cyc();
      cyc();
      chk("reset_busy", busy, 0);
      chk("reset_valid", spawn.spawn_valid, 0);
      chk("reset_step", rng_step, 0);
      chk("reset_kind", spawn.spawn_kind, 0);
      game_run = 1'b1;
      cyc();
      chk("reset_overrides_run", busy, 0);
      sys_rst = 1'b0;
      steps = 0;
      exp_gap = MIN_GAP;
      run_obs(0, 0, 0);
      run_obs(0, 0, 0);
      run_obs(0, 10, 15);
      repeat (6) run_obs(0, $urandom_range(0, 4), $urandom_range(0, 15));
      run_obs(1, 0, 5);
      run_obs(0, 0, 2);
      run_obs(2, 0, 7);
      run_obs(0, 2, 1);
      run_obs(3, 0, 3);
      run_obs(0, 1, 9);
      stub_en = 1'b1;
      run_obs(0, 0, 3);
      run_obs(0, 0, 4);
      stub_en = 1'b0;
      run_obs(0, 0, 0);
      run_obs(0, 3, $urandom_range(0, 15));
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
